pkt_out_arbiter: RTL

//  Packet-granular 2:1 AXI-Stream arbiter merging two pipeline packet streams (port 0: pkt_filter data

---
 rtl/pkt_out_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pkt_out_arbiter.sv
// pkt_out_arbiter: packet-granular 2:1 AXI-Stream arbiter with a registered output stage and per-port packet counters.
// Build option: define PKT_ARB_STRICT_PRIO_EN for strict port-0 priority instead of round-robin arbitration.
module pkt_out_arbiter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                                clk,
    input  logic                                aresetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s0_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s0_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s0_axis_tuser,
    input  logic                                s0_axis_tvalid,
    input  logic                                s0_axis_tlast,
    output logic                                s0_axis_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s1_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s1_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s1_axis_tuser,
    input  logic                                s1_axis_tvalid,
    input  logic                                s1_axis_tlast,
    output logic                                s1_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    input  logic                                m_axis_tready,

    output logic [31:0]                         pkt_cnt_0,
    output logic [31:0]                         pkt_cnt_1
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FWD  = 1'b1
    } state_t;

    state_t          state;
    logic            grant;
    logic            last_grant;
    logic            arb_pick;
    logic            out_open;
    logic            accept;

    logic [DW-1:0]   sel_tdata;
    logic [KW-1:0]   sel_tkeep;
    logic [UW-1:0]   sel_tuser;
    logic            sel_tvalid;
    logic            sel_tlast;

    // Handshake: a beat moves on a rising edge where tvalid & tready are both high; a source
    // holds its beat stable until then, and no tready here depends on that same port's tvalid.
    assign out_open       = ~m_axis_tvalid | m_axis_tready;
    assign s0_axis_tready = (state == ST_FWD) & ~grant & out_open;
    assign s1_axis_tready = (state == ST_FWD) &  grant & out_open;

    always_comb begin
        sel_tdata  = s0_axis_tdata;
        sel_tkeep  = s0_axis_tkeep;
        sel_tuser  = s0_axis_tuser;
        sel_tvalid = s0_axis_tvalid;
        sel_tlast  = s0_axis_tlast;
        if (grant) begin
            sel_tdata  = s1_axis_tdata;
            sel_tkeep  = s1_axis_tkeep;
            sel_tuser  = s1_axis_tuser;
            sel_tvalid = s1_axis_tvalid;
            sel_tlast  = s1_axis_tlast;
        end
    end

    assign accept = (state == ST_FWD) & sel_tvalid & out_open;

`ifdef PKT_ARB_STRICT_PRIO_EN
    // Port 1 is only picked when port 0 has nothing to offer.
    assign arb_pick = ~s0_axis_tvalid;
`else
    always_comb begin
        arb_pick = s1_axis_tvalid;
        if (s0_axis_tvalid & s1_axis_tvalid) begin
            arb_pick = ~last_grant;
        end
    end
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            pkt_cnt_0  <= 32'd0;
            pkt_cnt_1  <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s0_axis_tvalid | s1_axis_tvalid) begin
                        grant <= arb_pick;
                        state <= ST_FWD;
                    end
                end
                ST_FWD: begin
                    // The grant is held until the tlast beat transfers, however long the source stalls.
                    if (accept & sel_tlast) begin
                        last_grant <= grant;
                        if (grant) begin
                            pkt_cnt_1 <= pkt_cnt_1 + 32'd1;
                        end else begin
                            pkt_cnt_0 <= pkt_cnt_0 + 32'd1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (accept) begin
            m_axis_tdata  <= sel_tdata;
            m_axis_tkeep  <= sel_tkeep;
            m_axis_tuser  <= sel_tuser;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= sel_tlast;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule
